// File: rtl/msg_mem_sched.sv
//------------------------------------------------------------------------------
// msg_mem_sched
//
// Sequencer and port-B arbiter for the 768x52 two-port LDPC message SRAM.
//   * Port A: programmable circular read sweep (base, length), wrapping
//     DEPTH-1 -> 0, with registered read-return qualifiers.
//   * Port B: merges decoder write-back and host/channel load. Write-back has
//     priority; a host that has been blocked for STARVE consecutive cycles is
//     forced through for one cycle.
//   * A sweep read that targets the address being written in the same cycle
//     is held back one cycle, so the decoder always reads the fresh word.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               one-cycle pulse; starts a sweep when idle
//   i_sweep_base/_len     first address / word count, sampled on i_start
//   o_busy, o_done        sweep in progress / one-cycle completion pulse
//   o_rd_valid/_last      DOUTA holds the word for o_rd_addr_q (last of sweep)
//   o_rd_addr_q           address whose data is on DOUTA this cycle
//   i_wb_*, o_wb_ready    decoder write-back request channel
//   i_host_*, o_host_ack  host write request channel
//   o_mem_*               SRAM port A (read) / port B (write) controls
//   o_state               current sequencer state, for observation
//
// Handshake: a write-back transfers in every cycle where i_wb_valid and
// o_wb_ready are both high; a host write transfers in every cycle where
// o_host_ack is high (o_host_ack implies i_host_req). The accepted write is
// committed at the clock edge that ends that cycle.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module msg_mem_sched #(
    parameter int DEPTH  = 768,
    parameter int AW     = 10,
    parameter int DW     = 52,
    parameter int STARVE = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_sweep_base,
    input  logic [AW-1:0] i_sweep_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_valid,
    output logic          o_rd_last,
    output logic [AW-1:0] o_rd_addr_q,
    input  logic          i_wb_valid,
    output logic          o_wb_ready,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_din,
    input  logic          i_host_req,
    output logic          o_host_ack,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_din,
    output logic          o_mem_ena,
    output logic [AW-1:0] o_mem_addra,
    output logic          o_mem_enb,
    output logic          o_mem_web,
    output logic [AW-1:0] o_mem_addrb,
    output logic [DW-1:0] o_mem_dinb,
    output logic [1:0]    o_state
);

    localparam int            SW        = $clog2(STARVE + 1);
    localparam logic [AW-1:0] LP_DEPTH  = AW'(DEPTH);
    localparam logic [AW-1:0] LP_LAST   = AW'(DEPTH - 1);
    localparam logic [SW-1:0] LP_STARVE = SW'(STARVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [AW-1:0] r_remaining, w_remaining_nxt;
    logic [SW-1:0] r_starve, w_starve_nxt;
    logic          r_rd_valid, r_rd_last;
    logic [AW-1:0] r_rd_addr_q;

    logic          w_force;
    logic          w_wb_ready, w_wb_win, w_host_ack;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_din;
    logic          w_issue, w_stall;
    logic [AW-1:0] w_len_clamped;

    assign w_len_clamped = (i_sweep_len > LP_DEPTH) ? LP_DEPTH : i_sweep_len;
    assign w_force       = (r_starve == LP_STARVE);

    //--------------------------------------------------------------------------
    // Port-B arbitration. Everything is gated by i_rst so that asserting reset
    // disables the write port immediately, not at the next edge.
    //--------------------------------------------------------------------------
    always_comb begin
        w_wb_ready = 1'b1;
        w_wb_win   = 1'b0;
        w_host_ack = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_addr  = '0;
        w_wr_din   = '0;
        if (!i_rst) begin
            w_wb_ready = ~w_force;
            w_wb_win   = i_wb_valid & ~w_force;
            w_host_ack = i_host_req & (w_force | ~i_wb_valid);
            if (w_wb_win) begin
                w_wr_en   = 1'b1;
                w_wr_addr = i_wb_addr;
                w_wr_din  = i_wb_din;
            end else if (w_host_ack) begin
                w_wr_en   = 1'b1;
                w_wr_addr = i_host_addr;
                w_wr_din  = i_host_din;
            end
        end
    end

    // Counts consecutive blocked host cycles; a forced cycle always acks or
    // sees no request, so the count never passes STARVE.
    always_comb begin
        w_starve_nxt = '0;
        if (i_host_req && !w_host_ack && (r_starve != LP_STARVE)) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Sweep sequencer: next state and port-A issue.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_issue         = 1'b0;
        w_stall         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_sweep_len == '0) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_addr_nxt      = i_sweep_base;
                        w_remaining_nxt = w_len_clamped;
                        w_state_nxt     = ST_SWEEP;
                    end
                end
            end
            ST_SWEEP: begin
                // Same-cycle write to the word about to be read: hold the
                // read so it samples the SRAM after the write has landed.
                w_stall = w_wr_en && (w_wr_addr == r_addr);
                if (!w_stall) begin
                    w_issue         = 1'b1;
                    w_addr_nxt      = (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == AW'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: w_state_nxt = ST_FIN;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_starve    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_addr_q <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_starve    <= w_starve_nxt;
            r_rd_valid  <= w_issue;
            r_rd_last   <= w_issue && (r_remaining == AW'(1));
            if (w_issue) begin
                r_rd_addr_q <= r_addr;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign o_busy      = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign o_done      = (r_state == ST_FIN);
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_last   = r_rd_last;
    assign o_rd_addr_q = r_rd_addr_q;
    assign o_wb_ready  = w_wb_ready;
    assign o_host_ack  = w_host_ack;
    assign o_mem_ena   = ~w_issue;
    assign o_mem_addra = r_addr;
    assign o_mem_enb   = ~w_wr_en;
    assign o_mem_web   = w_wr_en;
    assign o_mem_addrb = w_wr_addr;
    assign o_mem_dinb  = w_wr_din;
    assign o_state     = r_state;

endmodule

// File: doc/msg_mem_sched.md
# msg_mem_sched

Sequencer and port-B arbiter for one 768x52 two-port message SRAM in the LDPC decoder. It walks port A through a programmable circular read sweep for the check/variable-node pipeline. It merges two write sources onto port B: decoder write-back and host/channel load. It also stalls reads that collide with a same-cycle write to the same address, so the decoder always reads fresh data.

## Interface
- DEPTH, 768, number of SRAM words
- AW, 10, address width
- DW, 52, data width
- STARVE, 8, consecutive blocked host cycles before host is forced through

- CLK  in  1  single clock; SRAM CLKA and CLKB both tie to CLK
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; begins a sweep when idle
- SWEEP_BASE  in  AW  first read address, sampled on START
- SWEEP_LEN  in  AW  words to read, sampled on START
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle pulse; sweep finished
- RD_VALID  out  1  DOUTA holds word for RD_ADDR_Q this cycle
- RD_LAST  out  1  qualifies final RD_VALID of sweep
- RD_ADDR_Q  out  AW  address whose data is on DOUTA
- WB_VALID  in  1  decoder write-back request
- WB_READY  out  1  write-back accepted when WB_VALID & WB_READY
- WB_ADDR  in  AW  write-back address
- WB_DIN  in  DW  write-back data
- HOST_REQ  in  1  host write request
- HOST_ACK  out  1  host write accepted this cycle
- HOST_ADDR  in  AW  host write address
- HOST_DIN  in  DW  host write data
- MEM_ENA  out  1  SRAM port-A enable, active low
- MEM_ADDRA  out  AW  SRAM port-A address
- MEM_ENB  out  1  SRAM port-B enable, active low
- MEM_WEB  out  1  SRAM port-B write, active high
- MEM_ADDRB  out  AW  SRAM port-B address
- MEM_DINB  out  DW  SRAM port-B data

## Operation
- Reset values:
  - FSM = IDLE; all counters = 0.
  - BUSY, DONE, RD_VALID, RD_LAST, HOST_ACK, MEM_WEB = 0.
  - MEM_ENA, MEM_ENB = 1 (disabled).
  - WB_READY = 1; all address outputs = 0.
- FSM states IDLE, SWEEP, DRAIN, FIN.
- IDLE:
  - START with SWEEP_LEN = 0 -> FIN; DONE pulses with no reads.
  - Otherwise START loads addr = SWEEP_BASE and remaining = min(SWEEP_LEN, 768), then -> SWEEP.
- START outside IDLE is ignored.
- SWEEP:
  - Each non-stalled cycle: MEM_ENA = 0, MEM_ADDRA = addr, then addr advances and remaining decrements.
  - addr advances 767 -> 0 (wrap); otherwise +1.
  - The read that brings remaining to 0 -> DRAIN.
- DRAIN: one cycle to collect the last read word -> FIN.
- FIN: DONE = 1 for one cycle -> IDLE.
- BUSY = 1 in SWEEP and DRAIN.
- Port-B arbitration, combinational each cycle:
  - Default: write-back has priority. WB_READY = 1; HOST_ACK = HOST_REQ & ~WB_VALID.
  - A starve counter increments each cycle HOST_REQ = 1 and HOST_ACK = 0, and clears on HOST_ACK or when HOST_REQ = 0.
  - When the counter reaches STARVE: WB_READY = 0 and HOST_ACK = HOST_REQ for that cycle (host forced through).
- Winner drives MEM_ADDRB and MEM_DINB, with MEM_ENB = 0 and MEM_WEB = 1. With no winner: MEM_ENB = 1, MEM_WEB = 0.
- Hazard: in SWEEP, if MEM_ENB = 0 and MEM_ADDRB == addr, the read stalls.
  - MEM_ENA = 1; addr and remaining hold.
  - The read issues on the next non-colliding cycle and returns the new data.
- Addresses >= 768 on WB_ADDR or HOST_ADDR are out of contract; no check is made.

## Timing
- A read issued in cycle N (MEM_ENA = 0) gives RD_VALID = 1 in cycle N+1, with RD_ADDR_Q = the issued address. RD_LAST = 1 on the final one.
- RD_VALID, RD_LAST and RD_ADDR_Q are registered.
- Unstalled sweep of L words:
  - START at cycle 0; reads issue at cycles 1..L.
  - RD_VALID at cycles 2..L+1.
  - DONE at cycle L+2; BUSY is high during cycles 1..L+1.
- Each stall adds exactly 1 cycle.
- Port B: a write accepted in cycle N is committed at the CLK edge ending cycle N.
- A read of the same address in cycle N+1 returns the new data.
- RST asserted mid-sweep: immediately disables both SRAM ports and drops BUSY, RD_VALID and DONE. No DONE is issued for the aborted sweep.

## Test plan
- Reset check: RST mid-sweep -> MEM_ENA = 1, MEM_ENB = 1, BUSY = 0 asynchronously; IDLE after release.
- Basic sweep: BASE = 5, LEN = 4 -> reads 5,6,7,8 at cycles 1-4; RD_VALID cycles 2-5 with RD_LAST at 8; DONE at cycle 6.
- Wrap, LEN = 0 and clamp:
  - BASE = 766, LEN = 4 -> addresses 766,767,0,1.
  - LEN = 0 -> DONE at cycle 1, no MEM_ENA.
  - LEN = 1000 -> 768 reads.
- Hazard: during sweep, WB write addr 10 with data 0xABC in the cycle the sweep reaches 10 -> one-cycle stall; RD_VALID word at 10 = 0xABC; DONE delayed by 1.
- Arbitration and starvation: WB_VALID and HOST_REQ held high continuously -> HOST_ACK = 0 for 8 cycles. Cycle 9: HOST_ACK = 1, WB_READY = 0. Pattern repeats every 9 cycles.
- START while BUSY -> ignored; sweep address sequence and DONE timing unchanged.
